// File: rtl/detect_window_sequencer_pkg.sv
// Shared state encoding and datapath widths for the detect window sequencer
// and the accumulator/comparator stages around it.
package detect_window_sequencer_pkg;

   localparam int SAMPLE_W = 8;
   localparam int THRES_W  = 12;
   localparam int ACC_W    = 30;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACCUM    = 3'd1,
      ST_CLOSE    = 3'd2,
      ST_WAIT_ACC = 3'd3,
      ST_COMPARE  = 3'd4,
      ST_REPORT   = 3'd5
   } state_t;

endpackage

// File: rtl/detect_window_sequencer_if.sv
// Bundle of sample, accumulator, comparator and status signals around the
// sequencer; slave is the sequencer view, master the surrounding environment.
interface detect_window_sequencer_if;
   import detect_window_sequencer_pkg::*;

   logic                start;
   logic [THRES_W-1:0]  thres_in;
   logic                in_valid;
   logic                in_ready;
   logic [SAMPLE_W-1:0] s_real, s_imag, n_real, n_imag;
   logic [SAMPLE_W-1:0] sig_real, sig_imag, noi_real, noi_imag;
   logic                acc_ready, acc_done;
   logic                sig_standby, noi_standby;
   logic                sig_complete, noi_complete;
   logic [THRES_W-1:0]  comp_thres;
   logic                comp_ready, comp_out, comp_done;
   logic                busy, detect, timeout, result_valid;

   modport slave (
      input  start, thres_in, in_valid, s_real, s_imag, n_real, n_imag,
             sig_standby, noi_standby, sig_complete, noi_complete,
             comp_out, comp_done,
      output in_ready, sig_real, sig_imag, noi_real, noi_imag,
             acc_ready, acc_done, comp_thres, comp_ready,
             busy, detect, timeout, result_valid
   );

   modport master (
      output start, thres_in, in_valid, s_real, s_imag, n_real, n_imag,
             sig_standby, noi_standby, sig_complete, noi_complete,
             comp_out, comp_done,
      input  in_ready, sig_real, sig_imag, noi_real, noi_imag,
             acc_ready, acc_done, comp_thres, comp_ready,
             busy, detect, timeout, result_valid
   );

endinterface

// File: rtl/detect_window_sequencer_handshake_timer.sv
// Saturating wait counter shared by the downstream handshake states; expired
// fires on the cycle the count sits at TIMEOUT_CYC-1 while enabled.
module handshake_timer #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int            CW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] r_wait_cnt;
   logic          w_at_limit;

   assign w_at_limit = (r_wait_cnt == LIMIT);
   assign o_expired  = i_en && w_at_limit;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_wait_cnt <= '0;
      end else if (i_en && !w_at_limit) begin
         r_wait_cnt <= r_wait_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/detect_window_sequencer.sv
// Forwards one window of paired IQ samples into the signal/noise accumulators,
// then sequences accumulator completion and the comparator into a detect result.
module detect_window_sequencer
   import detect_window_sequencer_pkg::*;
#(
   parameter int WINDOW_LEN  = 256,
   parameter int CNT_W       = 12,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   detect_window_sequencer_if.slave      bus
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_LEN - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WINDOW_LEN);

   state_t              r_state, w_next_state;
   logic [CNT_W-1:0]    r_sample_cnt;
   logic [SAMPLE_W-1:0] r_sig_real, r_sig_imag, r_noi_real, r_noi_imag;
   logic [THRES_W-1:0]  r_comp_thres;
   logic                r_acc_ready, r_acc_done, r_comp_ready;
   logic                r_busy, r_detect, r_timeout, r_result_valid;
   logic                r_sig_seen, r_noi_seen;
   logic                w_in_ready, w_xfer, w_both_seen, w_abort;
   logic                w_tmr_clr, w_tmr_en, w_expired;

   assign w_in_ready  = (r_state == ST_ACCUM) && bus.sig_standby && bus.noi_standby;
   assign w_xfer      = w_in_ready && bus.in_valid;
   assign w_both_seen = (r_sig_seen || bus.sig_complete) && (r_noi_seen || bus.noi_complete);
   assign w_tmr_en    = (r_state == ST_WAIT_ACC) || (r_state == ST_COMPARE);
   assign w_tmr_clr   = (w_next_state != r_state);
   assign w_abort     = w_expired &&
                        (((r_state == ST_WAIT_ACC) && !w_both_seen) ||
                         ((r_state == ST_COMPARE)  && !bus.comp_done));

   handshake_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_expired (w_expired)
   );

   // NOTE: next state is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:     if (bus.start) w_next_state = ST_ACCUM;
         ST_ACCUM:    if (w_xfer && (r_sample_cnt == LAST_IDX)) w_next_state = ST_CLOSE;
         ST_CLOSE:    w_next_state = ST_WAIT_ACC;
         ST_WAIT_ACC: if (w_both_seen) w_next_state = ST_COMPARE;
                      else if (w_abort) w_next_state = ST_REPORT;
         ST_COMPARE:  if (bus.comp_done || w_abort) w_next_state = ST_REPORT;
         ST_REPORT:   w_next_state = ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_sample_cnt   <= '0;
         r_sig_real     <= '0;
         r_sig_imag     <= '0;
         r_noi_real     <= '0;
         r_noi_imag     <= '0;
         r_comp_thres   <= '0;
         r_acc_ready    <= 1'b0;
         r_acc_done     <= 1'b0;
         r_comp_ready   <= 1'b0;
         r_busy         <= 1'b0;
         r_detect       <= 1'b0;
         r_timeout      <= 1'b0;
         r_result_valid <= 1'b0;
         r_sig_seen     <= 1'b0;
         r_noi_seen     <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_acc_ready    <= w_xfer;
         // acc_done lags CLOSE by a cycle so it never overlaps the last acc_ready
         r_acc_done     <= (r_state == ST_CLOSE);
         r_comp_ready   <= (w_next_state == ST_COMPARE);
         r_busy         <= (w_next_state != ST_IDLE);
         r_result_valid <= (w_next_state == ST_REPORT);

         if ((r_state == ST_IDLE) && bus.start) begin
            r_comp_thres <= bus.thres_in;
            r_sample_cnt <= '0;
            r_timeout    <= 1'b0;
         end

         if (w_xfer) begin
            r_sig_real <= bus.s_real;
            r_sig_imag <= bus.s_imag;
            r_noi_real <= bus.n_real;
            r_noi_imag <= bus.n_imag;
            if (r_sample_cnt != FULL_CNT) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
         end

         if (r_state == ST_CLOSE) begin
            r_sig_seen <= 1'b0;
            r_noi_seen <= 1'b0;
         end else if (r_state == ST_WAIT_ACC) begin
            if (bus.sig_complete) r_sig_seen <= 1'b1;
            if (bus.noi_complete) r_noi_seen <= 1'b1;
         end

         if ((r_state == ST_COMPARE) && bus.comp_done) r_detect <= bus.comp_out;
         if (w_abort) r_timeout <= 1'b1;
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.sig_real     = r_sig_real;
   assign bus.sig_imag     = r_sig_imag;
   assign bus.noi_real     = r_noi_real;
   assign bus.noi_imag     = r_noi_imag;
   assign bus.acc_ready    = r_acc_ready;
   assign bus.acc_done     = r_acc_done;
   assign bus.comp_thres   = r_comp_thres;
   assign bus.comp_ready   = r_comp_ready;
   assign bus.busy         = r_busy;
   assign bus.detect       = r_detect;
   assign bus.timeout      = r_timeout;
   assign bus.result_valid = r_result_valid;

endmodule

// File: tb/tb_detect_window_sequencer.sv
// Directed bench: stub accumulators/comparator around the sequencer, with a
// negedge monitor recording strobe counts, sample order and event cycles.
module tb_detect_window_sequencer;
   import detect_window_sequencer_pkg::*;

   localparam int WIN = 4;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   int   cyc = 0, n_acc_ready = 0, n_acc_done = 0, n_overlap = 0, n_result = 0;
   int   t_acc_done = 0, t_noi_cmp = 0, t_comp_rise = 0, t_result = 0;
   logic comp_ready_q = 1'b0;
   logic [31:0] smp_q [$];

   int   sig_lat = 3, noi_lat = 3, cmp_lat = 2;
   logic cmp_en = 1'b1, cmp_val = 1'b1;
   int   sig_cd = -1, noi_cd = -1, cmp_cd = -1;
   logic cmp_prev = 1'b0;

   logic [7:0] pat_re [4] = '{8'h33, 8'hB3, 8'h73, 8'h37};

   detect_window_sequencer_if bus ();

   detect_window_sequencer #(
      .WINDOW_LEN  (WIN),
      .CNT_W       (12),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1);
   end

   // Accumulator and comparator stubs with programmable latency.
   always @(posedge clk) begin
      #1;
      bus.sig_complete = 1'b0;
      bus.noi_complete = 1'b0;
      bus.comp_done    = 1'b0;
      bus.comp_out     = 1'b0;
      if (sig_cd > 0) begin sig_cd--; if (sig_cd == 0) bus.sig_complete = 1'b1; end
      if (noi_cd > 0) begin noi_cd--; if (noi_cd == 0) bus.noi_complete = 1'b1; end
      if (cmp_cd > 0) begin
         cmp_cd--;
         if (cmp_cd == 0 && cmp_en) begin
            bus.comp_done = 1'b1;
            bus.comp_out  = cmp_val;
         end
      end
      if (bus.acc_done) begin sig_cd = sig_lat; noi_cd = noi_lat; end
      if (bus.comp_ready && !cmp_prev) cmp_cd = cmp_lat;
      cmp_prev = bus.comp_ready;
   end

   always @(negedge clk) begin
      cyc++;
      if (bus.acc_ready) begin
         n_acc_ready++;
         smp_q.push_back({bus.sig_real, bus.sig_imag, bus.noi_real, bus.noi_imag});
      end
      if (bus.acc_done) begin n_acc_done++; t_acc_done = cyc; end
      if (bus.acc_ready && bus.acc_done) n_overlap++;
      if (bus.noi_complete) t_noi_cmp = cyc;
      if (bus.comp_ready && !comp_ready_q) t_comp_rise = cyc;
      comp_ready_q = bus.comp_ready;
      if (bus.result_valid) begin n_result++; t_result = cyc; end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_word(input int i);
      logic [7:0] p;
      p = pat_re[i];
      return {p, ~p, p + 8'h01, 8'(8'h10 + i)};
   endfunction

   task automatic drive_pair(input int i);
      bus.s_real = pat_re[i];
      bus.s_imag = ~pat_re[i];
      bus.n_real = pat_re[i] + 8'h01;
      bus.n_imag = 8'(8'h10 + i);
   endtask

   task automatic send_pair(input int i);
      int   guard = 0;
      logic took  = 1'b0;
      bus.in_valid = 1'b1;
      drive_pair(i);
      while (!took && guard < 50) begin
         @(negedge clk);
         took = bus.in_ready;
         tick();
         guard++;
      end
      chk("xfer_accepted", {31'd0, took}, 32'd1);
   endtask

   task automatic begin_window(input logic [11:0] thr);
      bus.thres_in = thr;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic exp_det, input logic exp_tmo);
      int   k    = 0;
      logic seen = 1'b0;
      while (!seen && k < 100) begin
         @(negedge clk);
         seen = bus.result_valid;
         k++;
      end
      chk({tag, "_result_valid"}, {31'd0, seen}, 32'd1);
      chk({tag, "_detect"}, {31'd0, bus.detect}, {31'd0, exp_det});
      chk({tag, "_timeout"}, {31'd0, bus.timeout}, {31'd0, exp_tmo});
      tick();
   endtask

   initial begin
      int b_rdy, b_done, b_ovl, b_res;

      bus.start = 1'b0;   bus.thres_in = '0;   bus.in_valid = 1'b0;
      bus.s_real = '0;    bus.s_imag = '0;     bus.n_real = '0;  bus.n_imag = '0;
      bus.sig_standby = 1'b0;  bus.noi_standby = 1'b0;
      bus.sig_complete = 1'b0; bus.noi_complete = 1'b0;
      bus.comp_out = 1'b0;     bus.comp_done = 1'b0;

      // Reset state
      rst = 1'b1;
      tick(); tick();
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_acc_ready", {31'd0, bus.acc_ready}, 32'd0);
      chk("rst_comp_thres", {20'd0, bus.comp_thres}, 32'd0);
      chk("rst_detect", {31'd0, bus.detect}, 32'd0);
      chk("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
      chk("rst_sig_real", {24'd0, bus.sig_real}, 32'd0);
      rst = 1'b0;
      bus.sig_standby = 1'b1;
      bus.noi_standby = 1'b1;
      tick();

      // 1: nominal window, start and in_valid together
      b_rdy = n_acc_ready; b_done = n_acc_done; b_ovl = n_overlap; b_res = n_result;
      smp_q.delete();
      bus.in_valid = 1'b1;
      drive_pair(0);
      bus.thres_in = 12'h0C1;
      bus.start = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      bus.start = 1'b0;
      chk("w1_comp_thres", {20'd0, bus.comp_thres}, 32'h0C1);
      chk("w1_busy", {31'd0, bus.busy}, 32'd1);
      for (int i = 0; i < WIN; i++) send_pair(i);
      bus.in_valid = 1'b0;
      wait_result("w1", 1'b1, 1'b0);
      chk("w1_done_to_result", t_result - t_acc_done, 32'd7);
      tick(); tick(); tick();
      chk("w1_acc_ready_cnt", n_acc_ready - b_rdy, 32'd4);
      chk("w1_acc_done_cnt", n_acc_done - b_done, 32'd1);
      chk("w1_overlap", n_overlap - b_ovl, 32'd0);
      chk("w1_result_cnt", n_result - b_res, 32'd1);
      chk("w1_busy_after", {31'd0, bus.busy}, 32'd0);

      // 2: backpressure on sig_standby, comparator says no
      cmp_val = 1'b0;
      smp_q.delete();
      begin_window(12'h0A5);
      send_pair(0);
      send_pair(1);
      bus.sig_standby = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("bp_acc_ready", {31'd0, bus.acc_ready}, (i == 0) ? 32'd1 : 32'd0);
         tick();
      end
      bus.sig_standby = 1'b1;
      send_pair(2);
      send_pair(3);
      bus.in_valid = 1'b0;
      wait_result("w2", 1'b0, 1'b0);
      chk("w2_sample_cnt", smp_q.size(), 32'd4);
      for (int k = 0; k < 4; k++) chk("w2_sample_order", smp_q[k], exp_word(k));

      // 3: noise accumulator completes 6 cycles after the signal one
      cmp_val = 1'b1;
      noi_lat = 9;
      begin_window(12'h0C1);
      for (int i = 0; i < WIN; i++) send_pair(i);
      bus.in_valid = 1'b0;
      wait_result("w3", 1'b1, 1'b0);
      chk("w3_compare_after_noi", t_comp_rise - t_noi_cmp, 32'd1);
      chk("w3_done_to_result", t_result - t_acc_done, 32'd13);

      // 4: comparator never answers
      noi_lat = 3;
      cmp_en  = 1'b0;
      begin_window(12'h200);
      for (int i = 0; i < WIN; i++) send_pair(i);
      bus.in_valid = 1'b0;
      wait_result("w4", 1'b1, 1'b1);
      chk("w4_timeout_latency", t_result - t_comp_rise, 32'd16);
      chk("w4_comp_ready_low", {31'd0, bus.comp_ready}, 32'd0);
      cmp_en = 1'b1;

      // 5: reset after two samples, then a clean window
      begin_window(12'h321);
      send_pair(0);
      send_pair(1);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_acc_ready", {31'd0, bus.acc_ready}, 32'd0);
      chk("mid_rst_acc_done", {31'd0, bus.acc_done}, 32'd0);
      chk("mid_rst_comp_ready", {31'd0, bus.comp_ready}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("mid_rst_detect", {31'd0, bus.detect}, 32'd0);
      chk("mid_rst_timeout", {31'd0, bus.timeout}, 32'd0);
      rst = 1'b0;
      tick();
      b_rdy = n_acc_ready;
      begin_window(12'h123);
      chk("w5_comp_thres", {20'd0, bus.comp_thres}, 32'h123);
      for (int i = 0; i < WIN; i++) send_pair(i);
      bus.in_valid = 1'b0;
      wait_result("w5", 1'b1, 1'b0);
      chk("w5_acc_ready_cnt", n_acc_ready - b_rdy, 32'd4);

      // 6: start during ACCUM is ignored
      cmp_val = 1'b0;
      b_rdy = n_acc_ready; b_done = n_acc_done; b_res = n_result;
      begin_window(12'h0C1);
      send_pair(0);
      bus.in_valid = 1'b0;
      bus.thres_in = 12'hFFF;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      chk("w6_comp_thres", {20'd0, bus.comp_thres}, 32'h0C1);
      chk("w6_busy", {31'd0, bus.busy}, 32'd1);
      for (int i = 1; i < WIN; i++) send_pair(i);
      bus.in_valid = 1'b0;
      wait_result("w6", 1'b0, 1'b0);
      tick(); tick();
      chk("w6_acc_ready_cnt", n_acc_ready - b_rdy, 32'd4);
      chk("w6_acc_done_cnt", n_acc_done - b_done, 32'd1);
      chk("w6_result_cnt", n_result - b_res, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/detect_window_sequencer.md
Name: detect_window_sequencer

Overview:
- Control stage directly upstream of the two square_adder accumulators (signal path, noise path) and the comparator.
- Accepts a stream of paired IQ samples (signal + noise) and forwards exactly WINDOW_LEN pairs into the accumulators.
- Closes the window, waits for both accumulators to complete, then fires the comparator against a latched threshold.
- Returns a registered detect decision, plus a timeout flag if any downstream handshake stalls.

Parameters:
WINDOW_LEN, 256, sample pairs per detection window (legal range 1..4095)
CNT_W, 12, sample-counter width; must satisfy 2**CNT_W > WINDOW_LEN
TIMEOUT_CYC, 1024, maximum cycles to wait on accumulator complete or comparator done

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a window; ignored unless in IDLE
thres_in  in  12  threshold, latched on accepted start
in_valid  in  1  sample pair present on s_*/n_*
in_ready  out  1  sequencer accepts a pair this cycle (transfer = in_valid & in_ready)
s_real, s_imag  in  8  signal sample
n_real, n_imag  in  8  noise sample
sig_real, sig_imag  out  8  registered signal sample to the signal square_adder
noi_real, noi_imag  out  8  registered noise sample to the noise square_adder
acc_ready  out  1  sample strobe, shared by both square_adders
acc_done  out  1  window-close strobe, shared by both square_adders
sig_standby, noi_standby  in  1  accumulator able to take a sample
sig_complete, noi_complete  in  1  accumulator result stable
comp_thres  out  12  latched threshold to the comparator
comp_ready  out  1  comparator enable
comp_out  in  1  comparator decision
comp_done  in  1  comparator decision valid
busy  out  1  high in every state except IDLE
detect  out  1  registered comp_out from the last window
timeout  out  1  last window aborted on a handshake timeout
result_valid  out  1  one-cycle pulse; detect and timeout are valid

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0, including sample registers, comp_thres, detect and timeout.
  - Counters = 0.
- States: IDLE, ACCUM, CLOSE, WAIT_ACC, COMPARE, REPORT.
- IDLE:
  - in_ready = 0.
  - start → latch thres_in into comp_thres, clear sample_cnt, clear timeout, go to ACCUM.
  - detect holds its previous value.
- ACCUM:
  - in_ready = sig_standby & noi_standby.
  - On transfer: register the samples; assert acc_ready for exactly the next cycle, aligned with the registered samples; sample_cnt++.
  - One-cycle latency from input to accumulator.
  - When the transfer making sample_cnt == WINDOW_LEN occurs, go to CLOSE.
  - in_valid low or standby low: wait indefinitely, no timeout.
- CLOSE:
  - Assert acc_done for exactly 1 cycle, never coincident with acc_ready.
  - Clear wait_cnt; go to WAIT_ACC.
- WAIT_ACC:
  - Track sig_complete and noi_complete with sticky flags; the two may arrive on different cycles.
  - Both flags seen → go to COMPARE.
  - wait_cnt reaches TIMEOUT_CYC-1 → set timeout, go to REPORT.
- COMPARE:
  - Hold comp_ready = 1.
  - comp_done → capture comp_out into detect, drop comp_ready the next cycle, go to REPORT.
  - Timeout as in WAIT_ACC; detect is left unchanged on timeout.
- REPORT:
  - Pulse result_valid for 1 cycle, then return to IDLE.
  - Minimum window length = WINDOW_LEN + 4 cycles plus downstream latency.
- Boundaries:
  - start while busy: ignored.
  - start and in_valid together in IDLE: no sample is accepted that cycle.
  - WINDOW_LEN = 1: ACCUM → CLOSE after a single transfer.
  - Counters never wrap; sample_cnt saturates at WINDOW_LEN.
  - rst mid-window: immediate return to IDLE; all strobes are low in the cycle after rst is sampled.
  - Comparator threshold semantics belong to the comparator; this block only presents the latched threshold.

Decomposition:
- Shared package: state encoding enum, the 8-bit sample width, 12-bit threshold width and 30-bit accumulator width constants.
- One natural sub-module, handshake_timer: a wait_cnt counter with clear/enable inputs and an expired output, reused by WAIT_ACC and COMPARE.

Test Plan:
1. Nominal window (WINDOW_LEN=4):
   - Stimulus: thres=12'h0C1; 4 pairs with continuous in_valid; stub accumulators assert complete 3 cycles after acc_done; comparator returns comp_out=1 two cycles after comp_ready.
   - Required: exactly 4 acc_ready pulses, 1 acc_done pulse, comp_thres=12'h0C1, detect=1, single result_valid, timeout=0.
2. Backpressure:
   - Stimulus: drop sig_standby for 5 cycles mid-window.
   - Required: in_ready=0 during the drop; no acc_ready; sample order preserved (0x33, 0xB3, 0x73, 0x37 arrive in order).
3. Skewed completion:
   - Stimulus: noi_complete 6 cycles after sig_complete.
   - Required: COMPARE entered only after both complete flags are seen; result otherwise as in scenario 1.
4. Timeout (TIMEOUT_CYC=16):
   - Stimulus: never assert comp_done.
   - Required: result_valid asserted 16 cycles after COMPARE entry with timeout=1; detect keeps its prior value.
5. Reset mid-window:
   - Stimulus: rst after 2 of 4 samples.
   - Required: next cycle busy=0 and all strobes 0; a fresh start then completes normally.
6. Ignored start:
   - Stimulus: start pulse with thres=12'hFFF during ACCUM.
   - Required: comp_thres unchanged; window count unaffected.
